// File: rtl/prefetch_unit_pkg.sv
// rtl/prefetch_unit_pkg.sv - shared types and helpers for the instruction prefetch front end
package prefetch_unit_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
        logic        fault;
    } fetch_entry_t;

    localparam logic [31:0] FETCH_STRIDE = 32'd4;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/prefetch_unit_sync_fifo.sv
// rtl/prefetch_unit_sync_fifo.sv - registered power-of-two FIFO with flush and occupancy count
module sync_fifo #(
    parameter type T     = logic,
    parameter int  DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  T                           push_data,
    input  logic                       pop,
    input  logic                       flush,
    output T                           head,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    T              mem_q [DEPTH];
    T              mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // Next-state: flush wins; a push into a full queue is only taken alongside a pop.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are don't-care while the occupancy says empty.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/prefetch_unit.sv
// rtl/prefetch_unit.sv - sequential instruction prefetcher with redirect flush and stale-response drop
module prefetch_unit
    import prefetch_unit_pkg::*;
#(
    parameter int          DEPTH           = 4,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'h0
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_data,
    output logic        instr_fault,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    localparam int CW = $clog2(DEPTH+1);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;

    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;
    fetch_entry_t  head_entry;
    fetch_entry_t  push_entry;
    logic [CW:0]   credit_used;
    logic          req_fire;
    logic          rsp_live;
    logic          rsp_keep;
    logic          pop;

    // Credit check and handshake decode: queue slots are reserved for every request in flight.
    always_comb begin
        credit_used    = {1'b0, fifo_count} + {1'b0, outstanding_q};
        imem_req_valid = !reset && !redirect_valid
                         && (credit_used < (CW+1)'(DEPTH))
                         && (outstanding_q < CW'(MAX_OUTSTANDING));
        imem_req_addr  = fetch_pc_q;
        req_fire       = imem_req_valid && imem_req_ready;
        rsp_live       = imem_rsp_valid && (outstanding_q != '0);
        rsp_keep       = rsp_live && (drop_cnt_q == '0) && !redirect_valid;
        instr_valid    = !reset && !fifo_empty;
        pop            = instr_valid && instr_ready && !redirect_valid;
        instr_pc       = head_entry.pc;
        instr_data     = head_entry.data;
        instr_fault    = head_entry.fault;
    end

    // The oldest live request is outstanding_q words behind fetch_pc, so its PC is rebuilt here
    // instead of carrying a per-request PC alongside the memory.
    always_comb begin
        push_entry = '{pc:    fetch_pc_q - (32'(outstanding_q) << 2),
                       data:  imem_rsp_data,
                       fault: imem_rsp_err};
    end

    // Fetch PC, in-flight count and drop count; on redirect everything still in flight is stale.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_live);
        drop_cnt_d    = drop_cnt_q;
        if (redirect_valid) begin
            fetch_pc_d = word_align(redirect_pc);
            drop_cnt_d = outstanding_q - CW'(rsp_live);
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + FETCH_STRIDE;
            end
            if (rsp_live && (drop_cnt_q != '0)) begin
                drop_cnt_d = drop_cnt_q - CW'(1);
            end
        end
    end

    // Front-end state registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    sync_fifo #(
        .T     (fetch_entry_t),
        .DEPTH (DEPTH)
    ) u_queue (
        .clock     (clock),
        .reset     (reset),
        .push      (rsp_keep),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (redirect_valid),
        .head      (head_entry),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    a_rsp_without_request: assert property (@(posedge clock) disable iff (reset)
        !(imem_rsp_valid && (outstanding_q == '0)));

    a_no_overfill: assert property (@(posedge clock) disable iff (reset)
        !(rsp_keep && fifo_full && !pop));

endmodule

// File: tb/tb_prefetch_unit.sv
// tb/tb_prefetch_unit.sv - randomized and directed bench for prefetch_unit against an epoch-based model
module tb_prefetch_unit;

    localparam int          DEPTH    = 4;
    localparam int          MAXO     = 2;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data  = '0;
    logic        imem_rsp_err   = 1'b0;
    logic        instr_valid;
    logic        instr_ready    = 1'b0;
    logic [31:0] instr_pc;
    logic [31:0] instr_data;
    logic        instr_fault;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc    = '0;

    always #5 clock = ~clock;

    prefetch_unit #(
        .DEPTH           (DEPTH),
        .MAX_OUTSTANDING (MAXO),
        .RESET_PC        (RESET_PC)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_pc       (instr_pc),
        .instr_data     (instr_data),
        .instr_fault    (instr_fault),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } flight_t;

    int          total = 0;
    int          bad   = 0;
    flight_t     memq[$];
    logic [31:0] inq[$];
    logic [31:0] popped[$];
    logic        popped_fault[$];
    logic [31:0] fires[$];
    int          epoch     = 0;
    int          cyc       = 0;
    int          last_due  = 0;
    int          rsp_delay = 1;
    logic [31:0] exp_fetch = RESET_PC;
    logic        obs_iv;
    logic        obs_rv;
    logic [31:0] obs_pc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0] ^ 16'hBEEF, a[31:16] ^ 16'h1234};
    endfunction

    function automatic logic err_of(input logic [31:0] a);
        return (a[11:2] % 13) == 2;
    endfunction

    // One clock: drive inputs at negedge, check settled outputs, then advance the model.
    task automatic step(input logic rst, input logic irdy, input logic qrdy,
                        input logic redir, input logic [31:0] rpc);
        logic    rsp;
        logic    exp_rv;
        flight_t f;
        int      due;
        @(negedge clock);
        reset          = rst;
        instr_ready    = irdy;
        imem_req_ready = qrdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        rsp            = !rst && (memq.size() > 0) && (memq[0].due <= cyc);
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? word_of(memq[0].addr) : $urandom;
        imem_rsp_err   = rsp ? err_of(memq[0].addr) : 1'b0;
        #1;
        exp_rv = !rst && !redir && (inq.size() + memq.size() < DEPTH) && (memq.size() < MAXO);
        check("req_valid", imem_req_valid, exp_rv);
        check("instr_valid", instr_valid, !rst && inq.size() > 0);
        obs_iv = instr_valid;
        obs_rv = imem_req_valid;
        obs_pc = instr_pc;
        if (!rst && instr_valid && inq.size() > 0) begin
            check("instr_pc", instr_pc, inq[0]);
            check("instr_data", instr_data, word_of(inq[0]));
            check("instr_fault", instr_fault, err_of(inq[0]));
        end
        if (rst) begin
            memq.delete();
            inq.delete();
            epoch++;
            exp_fetch = RESET_PC;
            last_due  = cyc;
        end else begin
            if (instr_valid && irdy && !redir && inq.size() > 0) begin
                popped.push_back(instr_pc);
                popped_fault.push_back(instr_fault);
                void'(inq.pop_front());
            end
            if (rsp) begin
                f = memq.pop_front();
                if (!redir && f.epoch == epoch) inq.push_back(f.addr);
            end
            if (redir) begin
                epoch++;
                inq.delete();
                exp_fetch = {rpc[31:2], 2'b00};
            end else if (imem_req_valid && qrdy) begin
                check("req_addr", imem_req_addr, exp_fetch);
                fires.push_back(imem_req_addr);
                due = cyc + rsp_delay;
                if (due <= last_due) due = last_due + 1;
                memq.push_back('{addr: exp_fetch, epoch: epoch, due: due});
                last_due  = due;
                exp_fetch = exp_fetch + 32'd4;
            end
        end
        cyc++;
    endtask

    task automatic do_reset();
        repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        popped.delete();
        popped_fault.delete();
        fires.delete();
    endtask

    initial begin
        int r;

        // Streaming from reset: first instruction at cycle 2, one per cycle after.
        rsp_delay = 1;
        do_reset();
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        check("t1_iv_c0", obs_iv, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        check("t1_iv_c1", obs_iv, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        check("t1_iv_c2", obs_iv, 1'b1);
        check("t1_pc_c2", obs_pc, 32'h0);
        repeat (5) step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        check("t1_npop", popped.size(), 6);
        for (int i = 0; i < 6 && i < popped.size(); i++) check("t1_seq_pc", popped[i], 32'(4 * i));
        if (popped_fault.size() >= 4) begin
            check("t5_fault_4", popped_fault[1], 1'b0);
            check("t5_fault_8", popped_fault[2], 1'b1);
            check("t5_fault_c", popped_fault[3], 1'b0);
        end else begin
            check("t5_npop", popped_fault.size(), 4);
        end

        // Core stalled: exactly DEPTH requests, then drain in order.
        do_reset();
        repeat (12) step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        check("t2_fires", fires.size(), DEPTH);
        check("t2_rv_idle", obs_rv, 1'b0);
        check("t2_iv_full", obs_iv, 1'b1);
        repeat (4) step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        check("t2_npop", popped.size(), 4);
        for (int i = 0; i < 4 && i < popped.size(); i++) check("t2_drain_pc", popped[i], 32'(4 * i));

        // Two requests in flight with slow memory, redirect drops both.
        do_reset();
        rsp_delay = 3;
        repeat (2) step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'h100);
        repeat (14) step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        check("t3_npop_ge2", popped.size() >= 2, 1'b1);
        if (popped.size() >= 2) begin
            check("t3_first_pc", popped[0], 32'h100);
            check("t3_second_pc", popped[1], 32'h104);
        end

        // Redirect coinciding with a response and a pop.
        do_reset();
        rsp_delay = 1;
        repeat (5) step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        popped.delete();
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'h200);
        check("t4_iv_at_redirect", obs_iv, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        check("t4_iv_after", obs_iv, 1'b0);
        repeat (6) step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        check("t4_npop_ge2", popped.size() >= 2, 1'b1);
        if (popped.size() >= 2) begin
            check("t4_first_pc", popped[0], 32'h200);
            check("t4_second_pc", popped[1], 32'h204);
        end

        // Address wrap at the top of memory, then reset mid-stream.
        do_reset();
        repeat (3) step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        fires.delete();
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF);
        repeat (4) step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        check("t6_nfires_ge2", fires.size() >= 2, 1'b1);
        if (fires.size() >= 2) begin
            check("t6_fire_top", fires[0], 32'hFFFF_FFFC);
            check("t6_fire_wrap", fires[1], 32'h0);
        end
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        check("t6_rv_in_reset", obs_rv, 1'b0);
        check("t6_iv_in_reset", obs_iv, 1'b0);
        fires.delete();
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        check("t6_iv_after_reset", obs_iv, 1'b0);
        check("t6_nfires", fires.size(), 1);
        if (fires.size() >= 1) check("t6_restart_pc", fires[0], RESET_PC);

        // Random traffic: stalls on both sides, variable latency, redirects and resets.
        for (int i = 0; i < 4000; i++) begin
            rsp_delay = $urandom_range(1, 3);
            r = $urandom_range(0, 199);
            step(r == 0,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 3) != 0,
                 (r >= 1) && (r < 9),
                 (r == 1) ? 32'hFFFF_FFF8 : $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
